grid_access_ctrl: RTL and testbench

GRID_ACCESS_CTRL -- requirements
Module: grid_access_ctrl

---
 rtl/grid_access_ctrl.sv | 151 +++++++++++++++
 tb/tb_grid_access_ctrl.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_access_ctrl.sv
// Grid RAM arbiter for a two-player trail game: zero-fill, per-step head read/paint, renderer reads.
// States: IDLE wait | CLEAR zero-fill | RD1/RD2/WAIT read heads | WR1/WR2 paint heads | DONE report.
module grid_access_ctrl (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        tick,
  input  logic        clear_req,
  input  logic [5:0]  p1_x,
  input  logic [4:0]  p1_y,
  input  logic [5:0]  p2_x,
  input  logic [4:0]  p2_y,
  input  logic        vga_req,
  input  logic [10:0] vga_addr,
  output logic        vga_gnt,
  output logic        vga_rvalid,
  output logic [1:0]  vga_rdata,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [1:0]  ram_wdata,
  input  logic [1:0]  ram_rdata,
  output logic        step_done,
  output logic        p1_crash,
  output logic        p2_crash,
  output logic        busy,
  output logic        clear_done,
  output logic        tick_overrun
);

  typedef enum logic [2:0] {
    IDLE, CLEAR, RD1, RD2, WAIT, WR1, WR2, DONE
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [10:0] r_cnt;
  logic        r_pend;
  logic [10:0] r_a1;
  logic [10:0] r_a2;
  logic [1:0]  r_cell1;
  logic [1:0]  r_cell2;
  logic        r_p1_crash;
  logic        r_p2_crash;
  logic        r_clear_done;
  logic        r_vga_rvalid;
  logic        w_clear_go;
  logic        w_gnt;
  logic        w_same;

  assign w_clear_go = clear_req | r_pend;
  assign w_gnt      = vga_req & (r_state == IDLE) & ~tick & ~w_clear_go;
  assign w_same     = (r_a1 == r_a2);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      // Coming out of reset the grid contents are unknown, so start in CLEAR.
      r_state      <= CLEAR;
      r_cnt        <= '0;
      r_pend       <= 1'b0;
      r_a1         <= '0;
      r_a2         <= '0;
      r_cell1      <= '0;
      r_cell2      <= '0;
      r_p1_crash   <= 1'b0;
      r_p2_crash   <= 1'b0;
      r_clear_done <= 1'b0;
      r_vga_rvalid <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_clear_done <= (r_state == CLEAR) && (r_cnt == 11'h7FF);
      r_vga_rvalid <= w_gnt;
      r_cnt        <= (r_state == CLEAR) ? r_cnt + 11'd1 : 11'd0;
      if (r_state == IDLE && w_clear_go)
        r_pend <= 1'b0;
      else if (clear_req && r_state != IDLE)
        r_pend <= 1'b1;
      if (r_state == IDLE && tick && !w_clear_go) begin
        r_a1 <= {p1_y, p1_x};
        r_a2 <= {p2_y, p2_x};
      end
      if (r_state == RD2)  r_cell1 <= ram_rdata;
      if (r_state == WAIT) r_cell2 <= ram_rdata;
      if (r_state == WR2) begin
        r_p1_crash <= (r_cell1 != 2'd0) || w_same;
        r_p2_crash <= (r_cell2 != 2'd0) || w_same;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_clear_go) w_next = CLEAR;
               else if (tick)  w_next = RD1;
      CLEAR:   if (r_cnt == 11'h7FF) w_next = IDLE;
      RD1:     w_next = RD2;
      RD2:     w_next = WAIT;
      WAIT:    w_next = WR1;
      WR1:     w_next = WR2;
      WR2:     w_next = DONE;
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    vga_gnt      = 1'b0;
    vga_rvalid   = 1'b0;
    vga_rdata    = 2'd0;
    ram_addr     = 11'd0;
    ram_we       = 1'b0;
    ram_wdata    = 2'd0;
    step_done    = 1'b0;
    p1_crash     = 1'b0;
    p2_crash     = 1'b0;
    busy         = 1'b0;
    clear_done   = 1'b0;
    tick_overrun = 1'b0;
    // Reset forces every output low immediately, which also stops any RAM write in flight.
    if (!Reset) begin
      vga_gnt      = w_gnt;
      vga_rvalid   = r_vga_rvalid;
      vga_rdata    = r_vga_rvalid ? ram_rdata : 2'd0;
      step_done    = (r_state == DONE);
      p1_crash     = r_p1_crash;
      p2_crash     = r_p2_crash;
      busy         = (r_state != IDLE);
      clear_done   = r_clear_done;
      tick_overrun = tick && ((r_state != IDLE) || w_clear_go);
      case (r_state)
        CLEAR: begin
          ram_addr = r_cnt;
          ram_we   = 1'b1;
        end
        RD1:  ram_addr = r_a1;
        RD2:  ram_addr = r_a2;
        WR1: begin
          ram_addr  = r_a1;
          ram_we    = 1'b1;
          ram_wdata = 2'd1;
        end
        WR2: begin
          ram_addr  = r_a2;
          ram_we    = 1'b1;
          ram_wdata = 2'd2;
        end
        default: if (w_gnt) ram_addr = vga_addr;
      endcase
    end
  end

endmodule

// File: tb/tb_grid_access_ctrl.sv
// Directed bench for grid_access_ctrl with a behavioural single-port grid RAM.
module tb_grid_access_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        tick = 1'b0;
  logic        clear_req = 1'b0;
  logic [5:0]  p1_x = '0;
  logic [4:0]  p1_y = '0;
  logic [5:0]  p2_x = '0;
  logic [4:0]  p2_y = '0;
  logic        vga_req = 1'b0;
  logic [10:0] vga_addr = '0;
  logic        vga_gnt, vga_rvalid;
  logic [1:0]  vga_rdata;
  logic [10:0] ram_addr;
  logic        ram_we;
  logic [1:0]  ram_wdata;
  logic [1:0]  ram_rdata;
  logic        step_done, p1_crash, p2_crash, busy, clear_done, tick_overrun;

  logic [1:0]  mem [2048];
  logic        mem_fill = 1'b0;
  int          wr_in_reset = 0;
  int          n_chk = 0;
  int          n_fail = 0;

  grid_access_ctrl dut (
    .Clk(Clk), .Reset(Reset), .tick(tick), .clear_req(clear_req),
    .p1_x(p1_x), .p1_y(p1_y), .p2_x(p2_x), .p2_y(p2_y),
    .vga_req(vga_req), .vga_addr(vga_addr),
    .vga_gnt(vga_gnt), .vga_rvalid(vga_rvalid), .vga_rdata(vga_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .step_done(step_done), .p1_crash(p1_crash), .p2_crash(p2_crash),
    .busy(busy), .clear_done(clear_done), .tick_overrun(tick_overrun)
  );

  always #5 Clk = ~Clk;

  // Grid RAM: synchronous read, data one cycle after the address.
  always @(posedge Clk) begin
    if (mem_fill) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 2'd3;
    end else if (ram_we) begin
      mem[ram_addr] <= ram_wdata;
    end
    ram_rdata <= mem[ram_addr];
    if (Reset && ram_we) wr_in_reset <= wr_in_reset + 1;
  end

  typedef struct {
    logic [5:0]  p1x;
    logic [4:0]  p1y;
    logic [5:0]  p2x;
    logic [4:0]  p2y;
    logic [10:0] a1;
    logic [10:0] a2;
    logic        c1;
    logic        c2;
    logic [1:0]  v1;
    logic [1:0]  v2;
    logic        hold;
    logic        ovr;
    logic        clr;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic mid();
    @(negedge Clk);
  endtask

  // Entered just after the edge that begins the first CLEAR cycle.
  task automatic wait_clear(input string name);
    int n;
    int wr;
    int bad;
    wr  = 0;
    bad = 0;
    for (n = 0; n < 2100; n++) begin
      mid();
      if (clear_done) break;
      if (ram_we && ram_addr === wr[10:0] && ram_wdata === 2'd0 && busy) wr++;
      else bad++;
      cyc();
    end
    chk({name, "_cycles"}, n, 2048);
    chk({name, "_writes"}, wr, 2048);
    chk({name, "_bad"}, bad, 0);
    chk({name, "_busy"}, busy, 0);
  endtask

  task automatic vga_read(input string name, input logic [10:0] addr, input logic [1:0] exp);
    cyc();
    vga_req  = 1'b1;
    vga_addr = addr;
    mid();
    chk({name, "_gnt"}, vga_gnt, 1);
    chk({name, "_raddr"}, ram_addr, addr);
    chk({name, "_we"}, ram_we, 0);
    cyc();
    vga_req = 1'b0;
    mid();
    chk({name, "_rvalid"}, vga_rvalid, 1);
    chk({name, "_rdata"}, vga_rdata, exp);
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    string s;
    cyc();
    p1_x = v.p1x; p1_y = v.p1y; p2_x = v.p2x; p2_y = v.p2y;
    tick = 1'b1;
    if (v.hold) begin
      vga_req  = 1'b1;
      vga_addr = v.a2;
    end
    mid();
    s = $sformatf("v%0d_k0", idx);
    chk({s, "_gnt"}, vga_gnt, 0);
    chk({s, "_ovr"}, tick_overrun, 0);
    chk({s, "_busy"}, busy, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      // Scramble the coordinate inputs to prove they were latched.
      p1_x = 6'd63 - v.p1x; p1_y = 5'd31 - v.p1y;
      p2_x = 6'd63 - v.p2x; p2_y = 5'd31 - v.p2y;
      tick      = v.ovr && (k == 2);
      clear_req = v.clr && (k == 4);
      mid();
      s = $sformatf("v%0d_k%0d", idx, k);
      chk({s, "_busy"}, busy, 1);
      chk({s, "_done"}, step_done, (k == 6));
      chk({s, "_gnt"}, vga_gnt, 0);
      chk({s, "_ovr"}, tick_overrun, (v.ovr && k == 2));
      case (k)
        1: begin chk({s, "_addr"}, ram_addr, v.a1); chk({s, "_we"}, ram_we, 0); end
        2: begin chk({s, "_addr"}, ram_addr, v.a2); chk({s, "_we"}, ram_we, 0); end
        3: chk({s, "_we"}, ram_we, 0);
        4: begin
          chk({s, "_addr"}, ram_addr, v.a1);
          chk({s, "_we"}, ram_we, 1);
          chk({s, "_wd"}, ram_wdata, 1);
        end
        5: begin
          chk({s, "_addr"}, ram_addr, v.a2);
          chk({s, "_we"}, ram_we, 1);
          chk({s, "_wd"}, ram_wdata, 2);
        end
        default: begin
          chk({s, "_we"}, ram_we, 0);
          chk({s, "_c1"}, p1_crash, v.c1);
          chk({s, "_c2"}, p2_crash, v.c2);
        end
      endcase
    end
    tick      = 1'b0;
    clear_req = 1'b0;
    s = $sformatf("v%0d", idx);
    if (v.hold) begin
      cyc();
      mid();
      chk({s, "_hgnt"}, vga_gnt, 1);
      chk({s, "_haddr"}, ram_addr, v.a2);
      cyc();
      vga_req = 1'b0;
      mid();
      chk({s, "_hrvalid"}, vga_rvalid, 1);
      chk({s, "_hrdata"}, vga_rdata, v.v2);
    end else begin
      if (v.clr) begin
        cyc();
        mid();
        chk({s, "_idle_busy"}, busy, 0);
        chk({s, "_idle_we"}, ram_we, 0);
        cyc();
        wait_clear({s, "_clr"});
      end
      vga_read({s, "_rd1"}, v.a1, v.v1);
      vga_read({s, "_rd2"}, v.a2, v.v2);
    end
  endtask

  initial begin
    //               p1x    p1y    p2x    p2y    a1       a2       c1 c2 v1    v2    hold ovr clr
    vecs[0] = '{6'd3,  5'd2,  6'd10, 5'd2,  11'h083, 11'h08A, 0, 0, 2'd1, 2'd2, 0, 0, 0};
    vecs[1] = '{6'd3,  5'd2,  6'd10, 5'd2,  11'h083, 11'h08A, 1, 1, 2'd1, 2'd2, 0, 0, 0};
    vecs[2] = '{6'd20, 5'd5,  6'd20, 5'd5,  11'h154, 11'h154, 1, 1, 2'd2, 2'd2, 0, 0, 0};
    vecs[3] = '{6'd0,  5'd0,  6'd63, 5'd31, 11'h000, 11'h7FF, 0, 0, 2'd1, 2'd2, 0, 0, 0};
    vecs[4] = '{6'd63, 5'd31, 6'd5,  5'd0,  11'h7FF, 11'h005, 1, 0, 2'd1, 2'd2, 0, 0, 0};
    vecs[5] = '{6'd7,  5'd7,  6'd8,  5'd7,  11'h1C7, 11'h1C8, 0, 0, 2'd1, 2'd2, 1, 0, 0};
    vecs[6] = '{6'd9,  5'd3,  6'd9,  5'd4,  11'h0C9, 11'h109, 0, 0, 2'd0, 2'd0, 0, 1, 1};

    // Reset: fill RAM with garbage, then check outputs are forced low even with inputs active.
    mem_fill = 1'b1;
    cyc();
    mem_fill = 1'b0;
    tick     = 1'b1;
    vga_req  = 1'b1;
    cyc();
    mid();
    chk("rst_busy", busy, 0);
    chk("rst_we", ram_we, 0);
    chk("rst_gnt", vga_gnt, 0);
    chk("rst_ovr", tick_overrun, 0);
    chk("rst_done", step_done, 0);
    chk("rst_cdone", clear_done, 0);
    chk("rst_crash", {p1_crash, p2_crash}, 0);
    cyc();
    tick    = 1'b0;
    vga_req = 1'b0;
    Reset   = 1'b0;
    wait_clear("init");
    vga_read("init_rd", 11'h083, 2'd0);

    for (int i = 0; i < 7; i++) run_vec(vecs[i], i);

    // tick and clear_req together in IDLE: clear wins, tick is dropped.
    cyc();
    p1_x = 6'd1; p1_y = 5'd1; p2_x = 6'd2; p2_y = 5'd1;
    tick      = 1'b1;
    clear_req = 1'b1;
    mid();
    chk("tc_ovr", tick_overrun, 1);
    chk("tc_gnt", vga_gnt, 0);
    cyc();
    tick      = 1'b0;
    clear_req = 1'b0;
    wait_clear("tc_clr");

    // Reset mid-step: crash flags set, then Reset lands in WR1.
    run_vec(vecs[2], 7);
    cyc();
    p1_x = 6'd1; p1_y = 5'd1; p2_x = 6'd2; p2_y = 5'd1;
    tick = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      cyc();
      tick = 1'b0;
    end
    cyc();
    Reset = 1'b1;
    mid();
    chk("mr_we", ram_we, 0);
    chk("mr_busy", busy, 0);
    chk("mr_crash", {p1_crash, p2_crash}, 0);
    cyc();
    mid();
    chk("mr_we2", ram_we, 0);
    cyc();
    Reset = 1'b0;
    wait_clear("mr_clr");
    chk("mr_wr_in_reset", wr_in_reset, 0);
    chk("mr_crash_after", {p1_crash, p2_crash}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
